// File: rtl/k_means_pkg.sv
// Shared types and RAM control encodings for the point-RAM access arbiter.
package k_means_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

  typedef enum logic {
    PTR_CORE = 1'b0,
    PTR_HOST = 1'b1
  } rr_ptr_t;

  // {csb, web, oeb}, all active low
  localparam logic [2:0] RAM_IDLE  = 3'b111;
  localparam logic [2:0] RAM_READ  = 3'b010;
  localparam logic [2:0] RAM_WRITE = 3'b001;

endpackage

// File: rtl/ram_access_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a lock input that hands the core absolute priority.
module rr_arb2
  import k_means_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic lock_i,
  input  logic core_req_i,
  input  logic host_req_i,
  output logic core_gnt_o,
  output logic host_gnt_o
);

  rr_ptr_t ptr_q, ptr_d;

  always_comb begin
    core_gnt_o = 1'b0;
    host_gnt_o = 1'b0;
    if (lock_i) begin
      core_gnt_o = core_req_i;
    end else if (core_req_i && host_req_i) begin
      core_gnt_o = (ptr_q == PTR_CORE);
      host_gnt_o = (ptr_q == PTR_HOST);
    end else begin
      core_gnt_o = core_req_i;
      host_gnt_o = host_req_i;
    end
  end

  // The pointer always moves to the side that lost, including locked core grants.
  always_comb begin
    ptr_d = ptr_q;
    if (core_gnt_o) begin
      ptr_d = PTR_HOST;
    end else if (host_gnt_o) begin
      ptr_d = PTR_CORE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_CORE;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Shares the single-port point RAM between the host loader and the k-means core;
// registers the RAM controls and returns read data two cycles after the grant.
module ram_access_arbiter
  import k_means_pkg::*;
#(
  parameter int addr_width = 9,
  parameter int data_width = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  core_lock,
  input  logic                  core_req,
  input  logic [addr_width-1:0] core_addr,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  input  logic                  host_req,
  input  logic                  host_wr,
  input  logic [addr_width-1:0] host_addr,
  input  logic [data_width-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [data_width-1:0] rdata,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_wdata,
  input  logic [data_width-1:0] ram_rdata,
  output logic                  ram_csb,
  output logic                  ram_web,
  output logic                  ram_oeb
);

  logic                  core_req_v, host_req_v;
  logic [2:0]            ram_ctrl_q, ram_ctrl_d;
  logic [addr_width-1:0] ram_addr_q, ram_addr_d;
  logic [data_width-1:0] ram_wdata_q, ram_wdata_d;
  logic [data_width-1:0] rdata_q;
  owner_t                own1_q, own1_d, own2_q;

  // No grants are issued while reset is held, so no access is silently lost.
  assign core_req_v = core_req & rst_n;
  assign host_req_v = host_req & rst_n;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lock_i     (core_lock),
    .core_req_i (core_req_v),
    .host_req_i (host_req_v),
    .core_gnt_o (core_gnt),
    .host_gnt_o (host_gnt)
  );

  always_comb begin
    ram_ctrl_d  = RAM_IDLE;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    own1_d      = OWN_NONE;
    if (core_gnt) begin
      ram_ctrl_d = RAM_READ;
      ram_addr_d = core_addr;
      own1_d     = OWN_CORE;
    end else if (host_gnt) begin
      ram_addr_d = host_addr;
      if (host_wr) begin
        ram_ctrl_d  = RAM_WRITE;
        ram_wdata_d = host_wdata;
      end else begin
        ram_ctrl_d = RAM_READ;
        own1_d     = OWN_HOST;
      end
    end
  end

  // own1_q tags the cycle the RAM drives Q; own2_q tags the cycle rdata is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_ctrl_q  <= RAM_IDLE;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      own1_q      <= OWN_NONE;
      own2_q      <= OWN_NONE;
      rdata_q     <= '0;
    end else begin
      ram_ctrl_q  <= ram_ctrl_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      own1_q      <= own1_d;
      own2_q      <= own1_q;
      if (own1_q != OWN_NONE) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  assign {ram_csb, ram_web, ram_oeb} = ram_ctrl_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign rdata       = rdata_q;
  assign core_rvalid = (own2_q == OWN_CORE);
  assign host_rvalid = (own2_q == OWN_HOST);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter: queue-driven requesters, negedge-clocked RAM model,
// and a scoreboard that matches every rvalid pulse against owner, data and cycle.
module tb_ram_access_arbiter;

  localparam int AW = 9;
  localparam int DW = 50;
  localparam int EW = 2 + DW + 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          core_lock = 1'b0;
  logic          core_req = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic          core_gnt, core_rvalid;
  logic          host_req = 1'b0;
  logic          host_wr = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          ram_csb, ram_web, ram_oeb;

  ram_access_arbiter #(.addr_width(AW), .data_width(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .core_lock   (core_lock),
    .core_req    (core_req),
    .core_addr   (core_addr),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .host_req    (host_req),
    .host_wr     (host_wr),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .rdata       (rdata),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_csb     (ram_csb),
    .ram_web     (ram_web),
    .ram_oeb     (ram_oeb)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- RAM model: Q valid in the cycle the controls are presented ----------------
  logic [DW-1:0] mem    [512];
  logic [DW-1:0] sh_mem [512];

  function automatic logic [DW-1:0] pat(int a);
    return DW'(a) * 50'd1000003 + 50'd7;
  endfunction

  always @(negedge clk) begin
    if (!ram_csb) begin
      if (!ram_web) mem[ram_addr] <= ram_wdata;
      else if (!ram_oeb) ram_rdata <= mem[ram_addr];
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (core_gnt && host_gnt) chk("both_gnt", 1, 0);
    if (core_rvalid && host_rvalid) chk("both_rvalid", 1, 0);
    if (core_rvalid || host_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {62'd0, host_rvalid, core_rvalid}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rv_owner", core_rvalid ? 64'd1 : 64'd2, 64'(e[EW-1 -: 2]));
        chk("rv_data", 64'(rdata), 64'(e[DW+31:32]));
        chk("rv_cycle", 64'(cyc), 64'(e[31:0]));
      end
    end
  end

  // ---------------- drivers ----------------
  logic [AW-1:0]      core_q[$];
  logic [AW+DW:0]     host_q[$];  // {wr, addr, wdata}
  int                 last_side;  // 0 none, 1 core, 2 host

  function automatic logic [AW+DW:0] hcmd(input logic wr, input int a, input logic [DW-1:0] d);
    return {wr, AW'(a), d};
  endfunction

  // Present queue heads, sample grants on the falling edge, return 1 unit after the next rise.
  task automatic step();
    logic [AW+DW:0] hc;
    logic [AW-1:0]  ca;
    core_req  = (core_q.size() > 0);
    core_addr = core_req ? core_q[0] : '0;
    host_req  = (host_q.size() > 0);
    hc        = host_req ? host_q[0] : '0;
    host_wr   = hc[AW+DW];
    host_addr = hc[AW+DW-1:DW];
    host_wdata = hc[DW-1:0];
    @(negedge clk);
    last_side = 0;
    if (core_gnt) begin
      last_side = 1;
      if (core_q.size() == 0) chk("spurious_core_gnt", 1, 0);
      else begin
        ca = core_q.pop_front();
        exp_q.push_back({2'd1, sh_mem[ca], 32'(cyc + 2)});
      end
    end
    if (host_gnt) begin
      last_side = 2;
      if (host_q.size() == 0) chk("spurious_host_gnt", 1, 0);
      else begin
        hc = host_q.pop_front();
        if (hc[AW+DW]) sh_mem[hc[AW+DW-1:DW]] = hc[DW-1:0];
        else exp_q.push_back({2'd2, sh_mem[hc[AW+DW-1:DW]], 32'(cyc + 2)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]    = pat(i);
      sh_mem[i] = pat(i);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", {61'd0, ram_csb, ram_web, ram_oeb}, 64'b111);
    chk("reset_addr", 64'(ram_addr), 0);
    chk("reset_rdata", 64'(rdata), 0);
    rst_n = 1'b1;

    // Idle
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_gnt", 64'(last_side), 0);
      chk("idle_pins", {61'd0, ram_csb, ram_web, ram_oeb}, 64'b111);
    end

    // Host write 0x2A5 to 5, then read it back
    host_q.push_back(hcmd(1'b1, 5, 50'h2A5));
    step();
    chk("hw_gnt", 64'(last_side), 2);
    chk("hw_pins", {61'd0, ram_csb, ram_web, ram_oeb}, 64'b001);
    chk("hw_addr", 64'(ram_addr), 5);
    chk("hw_wdata", 64'(ram_wdata), 64'h2A5);
    host_q.push_back(hcmd(1'b0, 5, '0));
    step();
    chk("hr_gnt", 64'(last_side), 2);
    chk("hr_pins", {61'd0, ram_csb, ram_web, ram_oeb}, 64'b010);
    chk("hr_exp_data", 64'(sh_mem[5]), 64'h2A5);
    repeat (3) step();

    // Locked core stream 0..7 with host held
    core_lock = 1'b1;
    host_q.push_back(hcmd(1'b1, 9, 50'h1_5555));
    for (int i = 0; i < 8; i++) core_q.push_back(AW'(i));
    for (int i = 0; i < 8; i++) begin
      step();
      chk("lock_core_gnt", 64'(last_side), 1);
      chk("lock_host_held", 64'(host_q.size()), 1);
    end
    core_lock = 1'b0;
    host_q.push_back(hcmd(1'b0, 9, '0));
    step();
    chk("unlock_host_gnt", 64'(last_side), 2);
    step();
    chk("unlock_host_rd_gnt", 64'(last_side), 2);
    repeat (3) step();

    // Round-robin with both requesting
    for (int i = 0; i < 4; i++) core_q.push_back(AW'(16 + i));
    host_q.push_back(hcmd(1'b1, 32, 50'h1_2345));
    host_q.push_back(hcmd(1'b0, 32, '0));
    host_q.push_back(hcmd(1'b1, 33, 50'h3_FFFF_0000_0001));
    host_q.push_back(hcmd(1'b0, 33, '0));
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_alt", 64'(last_side), (i % 2 == 0) ? 64'd1 : 64'd2);
    end
    repeat (3) step();

    // Host read granted, lock rises next cycle
    host_q.push_back(hcmd(1'b0, 33, '0));
    step();
    chk("pre_lock_host_gnt", 64'(last_side), 2);
    core_lock = 1'b1;
    core_q.push_back(AW'(40));
    core_q.push_back(AW'(41));
    host_q.push_back(hcmd(1'b0, 6, '0));
    step();
    chk("lock_rise_core0", 64'(last_side), 1);
    step();
    chk("lock_rise_core1", 64'(last_side), 1);
    step();
    chk("lock_idle_host_held", 64'(last_side), 0);
    core_lock = 1'b0;
    step();
    chk("lock_fall_host", 64'(last_side), 2);
    repeat (3) step();

    // Reset the cycle after a core read grant
    core_q.push_back(AW'(3));
    step();
    chk("pre_rst_core_gnt", 64'(last_side), 1);
    chk("pre_rst_csb", 64'(ram_csb), 0);
    void'(exp_q.pop_back());
    #2 rst_n = 1'b0;
    #1 chk("rst_async_pins", {61'd0, ram_csb, ram_web, ram_oeb}, 64'b111);
    @(posedge clk);
    #1;
    repeat (2) step();
    rst_n = 1'b1;
    core_q.push_back(AW'(4));
    host_q.push_back(hcmd(1'b0, 5, '0));
    step();
    chk("post_rst_core_first", 64'(last_side), 1);
    step();
    chk("post_rst_host_next", 64'(last_side), 2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    chk("drain_exp_q", 64'(exp_q.size()), 0);
    chk("drain_cmds", 64'(core_q.size() + host_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
